decoded_inst_buffer: RTL and testbench
======================================

// Module: decoded_inst_buffer
// PURPOSE
//  Circular FIFO of decoded instruction records between the fetch/decode stage (InstQ outputs) and
//  the dispatch stage that allocates reservation-station/ROB slots. Absorbs dispatch back-pressure
//  so fetch can run ahead. Supports a single-cycle flush on branch mispredict or redirect.
// PARAMETERS
//  DEPTH   8   entries; power of 2, >=2; pointer width ADDR_W = $clog2(DEPTH) (localparam)
// PORTS
//  clk          in   1    rising-edge clock
//  rst          in   1    synchronous, active-high reset
//  flush        in   1    discard all entries (mispredict/redirect)
//  in_valid     in   1    upstream record valid
//  in_ready     out  1    buffer can accept = !full
//  in_opcode    in   12   {op[5:0],funct[5:0]}; funct zeroed for non-R-type
//  in_rs/in_rt/in_rd/in_shamt  in  5 each  register/shift fields
//  in_immediate in   16   I-type immediate
//  in_address   in   26   J-type target field
//  in_pc        in   32   PC of the instruction
//  out_valid    out  1    head record valid
//  out_ready    in   1    dispatch accepts head this cycle
//  out_opcode, out_rs, out_rt, out_rd, out_shamt, out_immediate, out_address, out_pc  out  (widths as in_*)
//  count        out  ADDR_W+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  - Storage: DEPTH x 106-bit records; wr_ptr/rd_ptr ADDR_W bits, wrap modulo DEPTH; count ADDR_W+1 bits.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at rising clk.
//  - in_ready = (count != DEPTH), combinational; no push-through when full even if popping.
//  - push only: write at wr_ptr, wr_ptr+1, count+1. pop only: rd_ptr+1, count-1.
//  - push & pop same cycle (count 1..DEPTH-1): both pointers advance, count unchanged.
//  - count==0: out_valid=0, pop impossible; all out_* fields driven 0.
//  - count>0: out_valid=1, out_* = record at rd_ptr (combinational array read).
//  - Latency (no bypass): record pushed at edge N visible on out_* after edge N.
//  - Order: strict FIFO; no reordering, no duplication, no drop except on flush/rst.
//  - flush=1 at edge: wr_ptr=rd_ptr=0, count=0; a push in the same cycle is dropped; a pop in
//    the same cycle is ignored. in_ready=1 the cycle after.
//  - Priority: rst > flush > push/pop.
//  - rst=1 at edge: pointers 0, count 0, storage not cleared. Outputs after rst: out_valid=0,
//    out_* = 0, count=0, in_ready=1. rst mid-stream discards all contents like flush.
//  - out_ready may be high while out_valid=0; it has no effect.
// CONFIGURATION
//  DIB_BYPASS_EN defined: when count==0 and in_valid=1 and flush=0, out_valid=1 and out_* = in_*
//   combinationally. If out_ready=1 that cycle, the record is consumed without being written
//   (pointers and count unchanged); otherwise it is written normally. Zero-cycle latency when empty.
//  DIB_BYPASS_EN undefined: no input-to-output combinational path; min latency 1 cycle as above.
// TESTING
//  1. rst then idle -> out_valid=0, count=0, in_ready=1, out_pc=0.
//  2. Push pc=0x10,0x14,0x18 (out_ready=0) -> count=3; raise out_ready -> out_pc 0x10,0x14,0x18
//     on consecutive cycles, then out_valid=0.
//  3. Push 8 records, out_ready=0 -> count=8, in_ready=0; a 9th in_valid is not accepted;
//     one pop -> in_ready=1, 9th accepted next cycle, order preserved across pointer wrap.
//  4. count=4, push and pop together for 10 cycles -> count stays 4, outputs in push order.
//  5. count=5, flush with in_valid=1 & out_ready=1 -> next cycle count=0, out_valid=0, flushed-cycle
//     record absent; next push appears at head.
//  6. DIB_BYPASS_EN, empty, in_valid=1, in_pc=0x40, out_ready=1 -> same cycle out_valid=1,
//     out_pc=0x40; next cycle count=0. Without macro -> out_valid=0 that cycle, 1 next cycle.

Source files
------------

// File: rtl/decoded_inst_buffer.sv
// Circular FIFO of decoded instruction records between decode and dispatch, with single-cycle flush.
// Optional feature: define DIB_BYPASS_EN to forward in_* straight to out_* when the buffer is empty.
module decoded_inst_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [11:0]              in_opcode,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_shamt,
  input  logic [15:0]              in_immediate,
  input  logic [25:0]              in_address,
  input  logic [31:0]              in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [11:0]              out_opcode,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_shamt,
  output logic [15:0]              out_immediate,
  output logic [25:0]              out_address,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   FULL_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  typedef struct packed {
    logic [11:0] opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] immediate;
    logic [25:0] address;
    logic [31:0] pc;
  } rec_t;

  rec_t              mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  rec_t              in_rec;
  rec_t              head_rec;
  logic              empty;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              wr_en;

  assign in_rec   = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_immediate, in_address, in_pc};
  assign empty    = (count_q == '0);
  assign in_ready = (count_q != FULL_CNT);
  assign push     = in_valid & in_ready;
  assign pop      = ~empty & out_ready;
  assign count    = count_q;

`ifdef DIB_BYPASS_EN
  assign bypass = empty & in_valid & ~flush & ~rst;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed record taken by dispatch in the same cycle never touches storage.
  assign wr_en = push & ~(bypass & out_ready);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_en && !pop)      count_d = count_q + CNT_ONE;
      else if (!wr_en && pop) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_en) mem_q[wr_ptr_q] <= in_rec;
  end

  always_comb begin
    out_valid = ~empty | bypass;
    head_rec  = '0;
    if (bypass)      head_rec = in_rec;
    else if (!empty) head_rec = mem_q[rd_ptr_q];
  end

  assign {out_opcode, out_rs, out_rt, out_rd, out_shamt,
          out_immediate, out_address, out_pc} = head_rec;

endmodule

// File: tb/tb_decoded_inst_buffer.sv
// Table-driven bench for decoded_inst_buffer (DEPTH=8): directed vectors plus hand sequences.
// Expected values follow the default build; bypass-dependent expectations switch on DIB_BYPASS_EN.
module tb_decoded_inst_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [11:0] in_opcode, out_opcode;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt, out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] in_immediate, out_immediate;
  logic [25:0] in_address, out_address;
  logic [31:0] in_pc, out_pc;
  logic [3:0]  count;

`ifdef DIB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [3:0]  exp_count;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  decoded_inst_buffer #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_immediate(in_immediate), .in_address(in_address), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_immediate(out_immediate), .out_address(out_address),
    .out_pc(out_pc), .count(count)
  );

  always #5 clk = ~clk;

  // Non-pc fields are a fixed scramble of the pc so every field carries distinct, checkable data.
  function automatic logic [73:0] fieldsOf(input logic [31:0] pc);
    logic [11:0] op;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] adr;
    op  = pc[13:2] ^ 12'h5A5;
    rs  = pc[6:2];
    rt  = ~pc[6:2];
    rd  = pc[10:6];
    sh  = pc[4:0] ^ 5'h15;
    imm = pc[17:2] ^ 16'hBEEF;
    adr = pc[27:2] ^ 26'h2AAAAAA;
    return {op, rs, rt, rd, sh, imm, adr};
  endfunction

  task automatic addV(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                      input logic ordy, input logic ev, input logic [31:0] epc,
                      input int ecnt, input logic erdy);
    vec_t v;
    v.rst = r; v.flush = f; v.in_valid = iv; v.in_pc = pc; v.out_ready = ordy;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_count = ecnt[3:0]; v.exp_ready = erdy;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    logic        ev;
    logic [31:0] epc;
    rst       = v.rst;
    flush     = v.flush;
    in_valid  = v.in_valid;
    in_pc     = v.in_pc;
    out_ready = v.out_ready;
    {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_immediate, in_address} = fieldsOf(v.in_pc);
    #2;
    ev  = v.exp_valid;
    epc = v.exp_pc;
    if (BYP && v.in_valid && !v.flush && !v.rst && v.exp_count == 4'd0) begin
      ev  = 1'b1;
      epc = v.in_pc;
    end
    checkOutput({tag, " out_valid"}, out_valid, ev);
    checkOutput({tag, " out_pc"},    out_pc,    epc);
    checkOutput({tag, " count"},     count,     v.exp_count);
    checkOutput({tag, " in_ready"},  in_ready,  v.exp_ready);
    checkOutput({tag, " fields"},
                {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_immediate, out_address},
                ev ? fieldsOf(epc) : 74'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t h;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0;
    {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_immediate, in_address} = '0;

    // Idle after reset
    addV(0,0,0,32'h0,0,  0,32'h0,0,1);
    // Three pushes then drain on consecutive cycles
    addV(0,0,1,32'h10,0, 0,32'h0,0,1);
    addV(0,0,1,32'h14,0, 1,32'h10,1,1);
    addV(0,0,1,32'h18,0, 1,32'h10,2,1);
    addV(0,0,0,32'h0,0,  1,32'h10,3,1);
    addV(0,0,0,32'h0,1,  1,32'h10,3,1);
    addV(0,0,0,32'h0,1,  1,32'h14,2,1);
    addV(0,0,0,32'h0,1,  1,32'h18,1,1);
    addV(0,0,0,32'h0,1,  0,32'h0,0,1);
    addV(0,0,0,32'h0,0,  0,32'h0,0,1);
    // Fill to full (pointers start at 3, so the drain wraps)
    for (int k = 0; k < 8; k++)
      addV(0,0,1,32'h100 + 4*k,0, k > 0, (k > 0) ? 32'h100 : 32'h0, k, 1);
    addV(0,0,1,32'h120,0, 1,32'h100,8,0);
    addV(0,0,1,32'h120,1, 1,32'h100,8,0);
    addV(0,0,1,32'h120,0, 1,32'h104,7,1);
    for (int j = 0; j < 8; j++)
      addV(0,0,0,32'h0,1, 1,32'h104 + 4*j, 8 - j, j > 0);
    addV(0,0,0,32'h0,0,  0,32'h0,0,1);
    // Steady push+pop at count 4
    for (int k = 0; k < 4; k++)
      addV(0,0,1,32'h200 + 4*k,0, k > 0, (k > 0) ? 32'h200 : 32'h0, k, 1);
    for (int i = 0; i < 10; i++)
      addV(0,0,1,32'h210 + 4*i,1, 1,32'h200 + 4*i,4,1);
    for (int j = 0; j < 4; j++)
      addV(0,0,0,32'h0,1, 1,32'h228 + 4*j, 4 - j, 1);
    addV(0,0,0,32'h0,0,  0,32'h0,0,1);
    // Flush at count 5 with a simultaneous push and pop
    for (int k = 0; k < 5; k++)
      addV(0,0,1,32'h300 + 4*k,0, k > 0, (k > 0) ? 32'h300 : 32'h0, k, 1);
    addV(0,1,1,32'h3FC,1, 1,32'h300,5,1);
    addV(0,0,0,32'h0,0,  0,32'h0,0,1);
    addV(0,0,1,32'h400,0, 0,32'h0,0,1);
    addV(0,0,0,32'h0,0,  1,32'h400,1,1);
    addV(0,0,0,32'h0,1,  1,32'h400,1,1);
    addV(0,0,0,32'h0,0,  0,32'h0,0,1);
    // Reset mid-stream discards contents and drops a same-cycle push
    addV(0,0,1,32'h500,0, 0,32'h0,0,1);
    addV(0,0,1,32'h504,0, 1,32'h500,1,1);
    addV(1,0,1,32'h508,0, 1,32'h500,2,1);
    addV(0,0,0,32'h0,0,  0,32'h0,0,1);
    addV(0,0,1,32'h600,0, 0,32'h0,0,1);
    addV(0,0,0,32'h0,1,  1,32'h600,1,1);
    addV(0,0,0,32'h0,0,  0,32'h0,0,1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], $sformatf("v%0d", i));

    // Empty buffer, record offered with dispatch ready
    h.rst = 0; h.flush = 0; h.in_valid = 1; h.in_pc = 32'h40; h.out_ready = 1;
    h.exp_valid = 0; h.exp_pc = 32'h0; h.exp_count = 4'd0; h.exp_ready = 1;
    applyStimulus(h, "byp0");
    h.in_valid = 0; h.in_pc = 32'h0;
`ifdef DIB_BYPASS_EN
    h.out_ready = 0;
    applyStimulus(h, "byp1");
`else
    h.out_ready = 0; h.exp_valid = 1; h.exp_pc = 32'h40; h.exp_count = 4'd1;
    applyStimulus(h, "byp1");
    h.out_ready = 1;
    applyStimulus(h, "byp2");
    h.out_ready = 0; h.exp_valid = 0; h.exp_pc = 32'h0; h.exp_count = 4'd0;
    applyStimulus(h, "byp3");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
